quad_decoder: RTL and testbench

Front-end for the rotary encoder on the lab board. It synchronizes and de-glitches the raw quadrature channels `a` and `b`, then decodes every legal Gray-code quarter step into a one-cycle `cw` or `ccw` pulse. It feeds the detent counter / BCD stage directly. That stage counts four pulses per detent and requires `cw` and `ccw` never to be high together. Illegal double-bit transitions are flagged and counted for board bring-up.

---
 rtl/quad_decoder_if.sv | 15 +
 rtl/quad_decoder.sv | 126 ++++++++++++
 tb/tb_quad_decoder.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/quad_decoder_if.sv
// Encoder pad / pulse bundle between the board pins, the decoder and the detent counter.
interface quad_decoder_if #(
  parameter int unsigned ERR_W = 8
);
  logic             a;
  logic             b;
  logic             clr_err;
  logic             cw;
  logic             ccw;
  logic             err;
  logic [ERR_W-1:0] err_count;

  modport master (output a, b, clr_err, input cw, ccw, err, err_count);
  modport slave  (input a, b, clr_err, output cw, ccw, err, err_count);
endinterface

// File: rtl/quad_decoder.sv
// Rotary-encoder front end: synchronize and de-glitch A/B, then decode Gray-code
// quarter steps into one-cycle cw/ccw pulses and flag/count illegal double-bit jumps.
module quad_decoder #(
  parameter int unsigned FILTER_LEN = 4,
  parameter int unsigned ERR_W      = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  quad_decoder_if.slave enc
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  localparam logic [3:0]       FILT_LAST = 4'(FILTER_LEN - 1);
  localparam logic [4:0]       INIT_LAST = 5'(FILTER_LEN + 2);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;

  logic             r_a_meta, r_a_s, r_b_meta, r_b_s;
  logic             r_a_f, r_b_f;
  logic [3:0]       r_a_cnt, r_b_cnt;
  state_t           r_state;
  logic [4:0]       r_init_cnt;
  logic [1:0]       r_prev;
  logic             r_cw, r_ccw, r_err;
  logic [ERR_W-1:0] r_err_count;

  logic [1:0]       w_cur;
  logic             w_step_cw, w_step_ccw, w_step_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a_meta <= 1'b0;
      r_a_s    <= 1'b0;
      r_b_meta <= 1'b0;
      r_b_s    <= 1'b0;
    end else begin
      r_a_meta <= enc.a;
      r_a_s    <= r_a_meta;
      r_b_meta <= enc.b;
      r_b_s    <= r_b_meta;
    end
  end

  // Filtered value flips only after FILTER_LEN consecutive disagreeing samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a_f   <= 1'b0;
      r_a_cnt <= '0;
    end else if (r_a_s == r_a_f) begin
      r_a_cnt <= '0;
    end else if (r_a_cnt == FILT_LAST) begin
      r_a_f   <= r_a_s;
      r_a_cnt <= '0;
    end else begin
      r_a_cnt <= r_a_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_b_f   <= 1'b0;
      r_b_cnt <= '0;
    end else if (r_b_s == r_b_f) begin
      r_b_cnt <= '0;
    end else if (r_b_cnt == FILT_LAST) begin
      r_b_f   <= r_b_s;
      r_b_cnt <= '0;
    end else begin
      r_b_cnt <= r_b_cnt + 4'd1;
    end
  end

  assign w_cur = {r_a_f, r_b_f};

  always_comb begin
    w_step_cw  = 1'b0;
    w_step_ccw = 1'b0;
    w_step_err = 1'b0;
    case ({r_prev, w_cur})
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: w_step_cw  = 1'b1;
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: w_step_ccw = 1'b1;
      4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: w_step_err = 1'b1;
      default: ;
    endcase
  end

  // prev tracks cur in both states so INIT silently absorbs the settling filters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_INIT;
      r_init_cnt  <= '0;
      r_prev      <= '0;
      r_cw        <= 1'b0;
      r_ccw       <= 1'b0;
      r_err       <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_prev <= w_cur;
      r_cw   <= 1'b0;
      r_ccw  <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_INIT: begin
          if (r_init_cnt == INIT_LAST) r_state <= S_RUN;
          else                         r_init_cnt <= r_init_cnt + 5'd1;
        end
        S_RUN: begin
          r_cw  <= w_step_cw;
          r_ccw <= w_step_ccw;
          r_err <= w_step_err;
        end
        default: r_state <= S_INIT;
      endcase
      if (enc.clr_err)
        r_err_count <= '0;
      else if (r_state == S_RUN && w_step_err && r_err_count != ERR_MAX)
        r_err_count <= r_err_count + ERR_W'(1);
    end
  end

  assign enc.cw        = r_cw;
  assign enc.ccw       = r_ccw;
  assign enc.err       = r_err;
  assign enc.err_count = r_err_count;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder: reset/INIT, cw/ccw steps with exact latency,
// glitch rejection, illegal-jump counting with saturation, clear priority, async reset.
module tb_quad_decoder;

  localparam int unsigned FL = 4;
  localparam int unsigned EW = 8;
  localparam int unsigned PT = FL + 3;   // tick index after pad change where the pulse is visible
  localparam int unsigned HOLD = 10;

  typedef enum int {K_NONE, K_CW, K_CCW, K_ERR} kind_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fails = 0;
  int   exp_cnt = 0;

  quad_decoder_if #(.ERR_W(EW)) enc ();

  quad_decoder #(.FILTER_LEN(FL), .ERR_W(EW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .enc     (enc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic ecw, input logic eccw, input logic eerr);
    check({tag, " cw"},  32'(enc.cw),  32'(ecw));
    check({tag, " ccw"}, 32'(enc.ccw), 32'(eccw));
    check({tag, " err"}, 32'(enc.err), 32'(eerr));
    check({tag, " err_count"}, 32'(enc.err_count), 32'(exp_cnt));
  endtask

  task automatic step(input logic na, input logic nb, input kind_t kind,
                      input int unsigned clr_at, input string tag);
    enc.a = na;
    enc.b = nb;
    for (int unsigned i = 1; i <= HOLD; i++) begin
      if (i == clr_at) enc.clr_err = 1'b1;
      tick();
      if (i == clr_at) exp_cnt = 0;
      else if (i == PT && kind == K_ERR && exp_cnt < 255) exp_cnt++;
      enc.clr_err = 1'b0;
      check_outs(tag, i == PT && kind == K_CW, i == PT && kind == K_CCW,
                 i == PT && kind == K_ERR);
    end
  endtask

  initial begin
    enc.a = 1'b1;
    enc.b = 1'b1;
    enc.clr_err = 1'b0;

    // Static reset with pads at 11
    repeat (3) begin
      tick();
      check_outs("in_reset", 1'b0, 1'b0, 1'b0);
    end
    reset_n = 1'b1;
    repeat (50) begin
      tick();
      check_outs("static", 1'b0, 1'b0, 1'b0);
    end

    // 11->10 being cw shows prev settled at 11; then the full cw cycle
    step(1'b1, 1'b0, K_CW, 0, "cw_from11");
    step(1'b0, 1'b0, K_CW, 0, "cw_to00");
    step(1'b0, 1'b1, K_CW, 0, "cw_01");
    step(1'b1, 1'b1, K_CW, 0, "cw_11");
    step(1'b1, 1'b0, K_CW, 0, "cw_10");
    step(1'b0, 1'b0, K_CW, 0, "cw_00");

    // Three-clock glitch on A is rejected
    enc.a = 1'b1;
    repeat (3) begin
      tick();
      check_outs("glitch_hi", 1'b0, 1'b0, 1'b0);
    end
    enc.a = 1'b0;
    repeat (12) begin
      tick();
      check_outs("glitch_lo", 1'b0, 1'b0, 1'b0);
    end

    step(1'b1, 1'b0, K_CCW, 0, "ccw_10");
    step(1'b1, 1'b1, K_CCW, 0, "ccw_11");
    step(1'b0, 1'b1, K_CCW, 0, "ccw_01");
    step(1'b0, 1'b0, K_CCW, 0, "ccw_00");

    // Illegal jumps, then saturation
    step(1'b1, 1'b1, K_ERR, 0, "err_first");
    check("err_count_one", 32'(enc.err_count), 32'd1);
    for (int k = 0; k < 300; k++) begin
      if (k % 2 == 0) step(1'b0, 1'b0, K_ERR, 0, "err_toggle");
      else            step(1'b1, 1'b1, K_ERR, 0, "err_toggle");
    end
    check("err_count_sat", 32'(enc.err_count), 32'd255);

    // clr_err on the same edge as an increment wins
    step(1'b0, 1'b0, K_ERR, PT, "clr_prio");
    check("err_count_cleared", 32'(enc.err_count), 32'd0);
    step(1'b1, 1'b1, K_ERR, 0, "err_after_clr");
    check("err_count_after_clr", 32'(enc.err_count), 32'd1);

    // Async reset while cw is high
    enc.a = 1'b1;
    enc.b = 1'b0;
    for (int unsigned i = 1; i <= PT; i++) begin
      tick();
      check_outs("pre_reset", i == PT, 1'b0, 1'b0);
    end
    #2 reset_n = 1'b0;
    exp_cnt = 0;
    #1;
    check("async_cw_drop", 32'(enc.cw), 32'd0);
    check("async_cnt_clear", 32'(enc.err_count), 32'd0);
    repeat (2) begin
      tick();
      check_outs("reset_hold", 1'b0, 1'b0, 1'b0);
    end

    // Pads move (double-bit) at release and glitch during INIT: all absorbed
    enc.a = 1'b0;
    enc.b = 1'b1;
    reset_n = 1'b1;
    for (int unsigned i = 1; i <= 20; i++) begin
      tick();
      check_outs("init_absorb", 1'b0, 1'b0, 1'b0);
      if (i == 2) enc.a = 1'b1;
      if (i == 4) enc.a = 1'b0;
    end
    step(1'b1, 1'b1, K_CW, 0, "post_reset_cw");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
